// File: rtl/spi_regs_pkg.sv
// spi_regs_pkg: shared definitions for the SPI register peripheral.
//   - register address map (0x00..0x04)
//   - frame length and bit-counter saturation value
//   - FSM state type used by spi_peripheral
package spi_regs_pkg;

  localparam logic [6:0] ADDR_EN_OUT_LO = 7'h00;
  localparam logic [6:0] ADDR_EN_OUT_HI = 7'h01;
  localparam logic [6:0] ADDR_EN_PWM_LO = 7'h02;
  localparam logic [6:0] ADDR_EN_PWM_HI = 7'h03;
  localparam logic [6:0] ADDR_PWM_DUTY  = 7'h04;

  localparam int FRAME_BITS = 16;

  // Counter stops one past a full frame so long frames stay distinguishable.
  localparam logic [4:0] CNT_SAT = 5'(FRAME_BITS + 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SHIFT  = 2'd1,
    COMMIT = 2'd2
  } spi_state_t;

endpackage

// File: rtl/spi_peripheral_sync_edge.sv
// sync_edge: multi-flop synchronizer for one asynchronous pin plus
// single-cycle rise/fall pulses derived from one extra history flop.
// Ports:
//   clk, rst_n : system clock, async active-low reset
//   d          : raw asynchronous pin
//   q          : synchronized level
//   rise, fall : one-cycle pulses on synchronized transitions
// The chain resets to 0 so a chip select held low across reset release
// produces no fall pulse and the in-flight frame is never entered.
module sync_edge #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q,
  output logic rise,
  output logic fall
);

  logic [STAGES-1:0] chain;
  logic              prev;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      chain <= '0;
      prev  <= 1'b0;
    end else begin
      chain <= {chain[STAGES-2:0], d};
      prev  <= chain[STAGES-1];
    end
  end

  assign q    = chain[STAGES-1];
  assign rise = q & ~prev;
  assign fall = ~q & prev;

endmodule

// File: rtl/spi_peripheral.sv
// spi_peripheral: SPI Mode-0 peripheral decoding 16-bit frames
// ({rw, addr[6:0], data[7:0]}, MSB first) into five 8-bit control registers.
// All SPI pins are oversampled on clk; none is used as a clock.
// Ports:
//   clk, rst_n        : system clock, async active-low reset
//   sclk, copi, ncs   : raw SPI pins
//   cipo              : SPI data out (0 unless SPI_READBACK_EN is defined)
//   en_reg_out_7_0    : reg 0x00      en_reg_out_15_8 : reg 0x01
//   en_reg_pwm_7_0    : reg 0x02      en_reg_pwm_15_8 : reg 0x03
//   pwm_duty_cycle    : reg 0x04
// Optional feature macro: SPI_READBACK_EN (read frames shift the addressed
// register out on cipo).
//
// state  | meaning
// IDLE   | waiting for ncs fall; sclk edges ignored
// SHIFT  | capturing copi on sclk rise until ncs rise
// COMMIT | one cycle; write register if frame is a valid 16-bit write
module spi_peripheral
  import spi_regs_pkg::*;
#(
  parameter int         SYNC_STAGES = 2,
  parameter logic [6:0] MAX_ADDR    = 7'h04
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       sclk,
  input  logic       copi,
  input  logic       ncs,
  output logic       cipo,
  output logic [7:0] en_reg_out_7_0,
  output logic [7:0] en_reg_out_15_8,
  output logic [7:0] en_reg_pwm_7_0,
  output logic [7:0] en_reg_pwm_15_8,
  output logic [7:0] pwm_duty_cycle
);

  logic sclk_s, sclk_rise, sclk_fall;
  logic copi_s, copi_rise, copi_fall;
  logic ncs_s, ncs_rise, ncs_fall;

  sync_edge #(.STAGES(SYNC_STAGES)) u_sync_sclk (
    .clk(clk), .rst_n(rst_n), .d(sclk), .q(sclk_s), .rise(sclk_rise), .fall(sclk_fall)
  );
  sync_edge #(.STAGES(SYNC_STAGES)) u_sync_copi (
    .clk(clk), .rst_n(rst_n), .d(copi), .q(copi_s), .rise(copi_rise), .fall(copi_fall)
  );
  sync_edge #(.STAGES(SYNC_STAGES)) u_sync_ncs (
    .clk(clk), .rst_n(rst_n), .d(ncs), .q(ncs_s), .rise(ncs_rise), .fall(ncs_fall)
  );

  spi_state_t  state;
  logic [15:0] shift_reg;
  logic [4:0]  bit_cnt;

  wire         frame_write = (bit_cnt == 5'(FRAME_BITS)) && shift_reg[15]
                             && (shift_reg[14:8] <= MAX_ADDR);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state           <= IDLE;
      shift_reg       <= '0;
      bit_cnt         <= '0;
      en_reg_out_7_0  <= '0;
      en_reg_out_15_8 <= '0;
      en_reg_pwm_7_0  <= '0;
      en_reg_pwm_15_8 <= '0;
      pwm_duty_cycle  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (ncs_fall) begin
            shift_reg <= '0;
            bit_cnt   <= '0;
            state     <= SHIFT;
          end
        end
        SHIFT: begin
          // ncs rise wins over a coincident sclk rise.
          if (ncs_rise) begin
            state <= COMMIT;
          end else if (sclk_rise) begin
            shift_reg <= {shift_reg[14:0], copi_s};
            if (bit_cnt != CNT_SAT) bit_cnt <= bit_cnt + 5'd1;
          end
        end
        COMMIT: begin
          if (frame_write) begin
            case (shift_reg[14:8])
              ADDR_EN_OUT_LO: en_reg_out_7_0  <= shift_reg[7:0];
              ADDR_EN_OUT_HI: en_reg_out_15_8 <= shift_reg[7:0];
              ADDR_EN_PWM_LO: en_reg_pwm_7_0  <= shift_reg[7:0];
              ADDR_EN_PWM_HI: en_reg_pwm_15_8 <= shift_reg[7:0];
              ADDR_PWM_DUTY:  pwm_duty_cycle  <= shift_reg[7:0];
              default: ;
            endcase
          end
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef SPI_READBACK_EN
  // The 8th captured bit completes {rw, addr}; it is copi_s itself at that edge.
  logic [6:0] rd_addr;
  logic [7:0] rd_data;
  logic [7:0] out_shift;
  logic       rd_load;

  assign rd_addr = {shift_reg[5:0], copi_s};
  assign rd_load = (state == SHIFT) && !ncs_rise && sclk_rise
                   && (bit_cnt == 5'd7) && !shift_reg[6];

  always_comb begin
    rd_data = 8'h00;
    if (rd_addr <= MAX_ADDR) begin
      case (rd_addr)
        ADDR_EN_OUT_LO: rd_data = en_reg_out_7_0;
        ADDR_EN_OUT_HI: rd_data = en_reg_out_15_8;
        ADDR_EN_PWM_LO: rd_data = en_reg_pwm_7_0;
        ADDR_EN_PWM_HI: rd_data = en_reg_pwm_15_8;
        ADDR_PWM_DUTY:  rd_data = pwm_duty_cycle;
        default:        rd_data = 8'h00;
      endcase
    end
  end

  // The fall right after the loading rise keeps bit7 on the line; the master
  // samples it on rise 9, so shifting starts from the fall after rise 9.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_shift <= '0;
      cipo      <= 1'b0;
    end else if (ncs_rise || state != SHIFT) begin
      out_shift <= '0;
      cipo      <= 1'b0;
    end else if (rd_load) begin
      out_shift <= rd_data;
      cipo      <= rd_data[7];
    end else if (sclk_fall && bit_cnt >= 5'd9) begin
      out_shift <= {out_shift[6:0], 1'b0};
      cipo      <= out_shift[6];
    end
  end
`else
  assign cipo = 1'b0;
`endif

endmodule

// File: doc/spi_peripheral.md
# spi_peripheral

SPI Mode-0 peripheral that sits directly upstream of the PWM peripheral inside `tt_um_uwasic_onboarding_WillPark`. It receives 16-bit frames on the SCLK/COPI/nCS pins through `ui_in` and decodes them into five 8-bit control registers. The registers drive the output-enable, PWM-enable and duty-cycle inputs of the PWM stage. All logic runs on the system clock; SPI pins are oversampled and are never used as clocks.

## Interface
- `SYNC_STAGES`, default 2: flip-flops in each pin synchronizer; legal range 2–3.
- `MAX_ADDR`, default 7'h04: highest writable register address.
- `clk`  in  1  system clock; the only clock in the block.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `sclk`  in  1  SPI clock pin; raw and asynchronous.
- `copi`  in  1  SPI data in; raw and asynchronous.
- `ncs`  in  1  SPI chip select, active-low; raw and asynchronous.
- `cipo`  out  1  SPI data out (see Configuration).
- `en_reg_out_7_0`  out  8  register 0x00.
- `en_reg_out_15_8`  out  8  register 0x01.
- `en_reg_pwm_7_0`  out  8  register 0x02.
- `en_reg_pwm_15_8`  out  8  register 0x03.
- `pwm_duty_cycle`  out  8  register 0x04.

## Operation
- Frame format, MSB first: bit15 is R/W (1 = write, 0 = read), bits14:8 are the address, bits7:0 are the data.
- Each of `sclk`, `copi` and `ncs` passes through `SYNC_STAGES` flops. One extra flop on `sclk` and `ncs` provides single-cycle rise/fall pulses.
- FSM states:
  - IDLE: waits for an `ncs` fall pulse, then clears the shift register and bit counter and goes to SHIFT.
  - SHIFT: on each `sclk` rise pulse, shifts synchronized `copi` into bit 0. The 5-bit bit counter saturates at 17. An `ncs` rise pulse moves the FSM to COMMIT.
  - COMMIT: lasts one cycle, then returns to IDLE. Write condition: count == 16, R/W = 1 and address ≤ `MAX_ADDR`. If the condition holds, the addressed register is written; otherwise the frame is silently discarded.
- Short frames (<16 bits) and long frames (>16 bits) are discarded, and registers are unchanged.
- Writes to addresses 0x05–0x7F are discarded.
- If an `sclk` rise pulse and an `ncs` rise pulse occur in the same cycle, the `sclk` edge is ignored.
- `sclk` edges seen while in IDLE are ignored.
- Reset mid-frame: all registers go to 8'h00, the FSM goes to IDLE and the partial frame is lost. The frame still in flight when `rst_n` is released is ignored until the next `ncs` fall.
- Register outputs change only in COMMIT and are stable in every other cycle.

## Timing
- Reset values: all five registers 8'h00, `cipo` 0, FSM in IDLE, shift register and counter 0.
- Pin-to-pulse latency is `SYNC_STAGES` + 1 clk cycles.
- Register update is visible at most `SYNC_STAGES` + 2 cycles after the `ncs` pin rises (4 cycles at default).
- SCLK high and low phases must each be ≥ `SYNC_STAGES` + 2 clk periods, i.e. f_SCLK ≤ f_clk/8 at default. Faster SCLK is out of spec.
- `ncs` high time between frames must be ≥ 2 clk cycles after COMMIT; back-to-back frames are otherwise supported.

## Configuration
- `SPI_READBACK_EN` defined:
  - For a read frame (R/W = 0), once the 8th bit is captured and the address is ≤ `MAX_ADDR`, the addressed register's value is loaded into an output shifter.
  - `cipo` presents data bit7 from the cycle after the load, and advances one bit on each `sclk` fall pulse (Mode 0).
  - `cipo` returns to 0 on the `ncs` rise pulse.
  - Reads never modify registers.
  - Reads of out-of-range addresses return 8'h00.
- `SPI_READBACK_EN` not defined: `cipo` is tied to 0, no output shifter is built, and read frames are discarded.

## Structure
- Package `spi_regs_pkg` holds:
  - address localparams `ADDR_EN_OUT_LO` = 0x00 through `ADDR_PWM_DUTY` = 0x04;
  - `FRAME_BITS` = 16;
  - the FSM state enum `spi_state_t` (IDLE, SHIFT, COMMIT).
- Sub-module `sync_edge`: parameterized synchronizer plus rise/fall pulse generator, instantiated once per pin (three instances). `copi` uses only its synchronized output.

## Test plan
- Reset: assert `rst_n`=0 for 5 cycles → all five outputs 8'h00 and `cipo`=0.
- Write 16'h80F0 at f_SCLK = f_clk/10 → `en_reg_out_7_0`=8'hF0 within 4 cycles of `ncs` rise; the other registers stay 0.
- Sequential writes 0x81:CC, 0x82:AA, 0x83:55, 0x84:80 → registers read back 8'hCC, 8'hAA, 8'h55, 8'h80, with duty 0x80 held stable.
- Invalid frames:
  - write 16'h8512 (address 5) → no register changes;
  - 15-bit frame and 17-bit frame, both targeting 0x04 → `pwm_duty_cycle` unchanged.
- Reset mid-frame: pull `rst_n` low after 9 SCLK bits of 16'h84FF → all 0; the next full frame 16'h8433 yields `pwm_duty_cycle`=8'h33.
- With `SPI_READBACK_EN` defined: after writing 0x84:A5, read frame 16'h0400 → `cipo` shifts 1,0,1,0,0,1,0,1; registers are unchanged.
